led_matrix_scroller: RTL and testbench
======================================

Name: led_matrix_scroller

Overview:
Parametrised scrolling-text engine for an ROWS x COLS serial RGB LED matrix (APA102/SK9822-style two-wire clock+data strip). It holds a writable glyph store of NUM_CHARS characters and renders a COLS-wide window of the message as one LED frame: a start word, one 32-bit word per LED, then end words. The window advances one column every STEP_FRAMES frames. Fg/bg colour and brightness are runtime inputs. Supports serpentine or linear wiring, serial clock division, and a static (non-scrolling) mode.

Parameters:
COLS, 8, matrix columns and glyph width in bits (2..16)
ROWS, 8, matrix rows and glyph height (2..16)
NUM_CHARS, 4, glyphs in message (power of 2, 1..16)
CLK_DIV, 0, serial bit half-period = CLK_DIV+1 clk cycles
SERPENTINE, 1, 1 = even rows wired right-to-left; 0 = all rows left-to-right
END_WORDS, 2, number of 32-bit zero end words (>=1)
STEP_FRAMES, 1, frames per scroll step (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  start/continue frames
scroll_en  in  1  1 = advance scroll; 0 = hold position
fg_rgb  in  24  lit-pixel colour {R[23:16],G[15:8],B[7:0]}
bg_rgb  in  24  unlit-pixel colour, same packing
brightness  in  5  global brightness field
glyph_we  in  1  glyph row write strobe
glyph_char  in  clog2(NUM_CHARS) (min 1)  glyph index
glyph_row  in  clog2(ROWS)  row within glyph
glyph_data  in  COLS  row bits; bit COLS-1 = leftmost column
led_clk  out  1  strip clock
led_data  out  1  strip data
busy  out  1  high while a frame is being shifted
frame_done  out  1  one-cycle pulse after last end bit

Behaviour:
- One clock; reset is synchronous and active-high. Clock port clk, reset port reset.
- Reset: led_clk=0, led_data=0, busy=0, frame_done=0, scroll_pos=0, frame counter=0, all glyph rows=0, state IDLE. Reset mid-frame aborts immediately; nothing further shifted.
- Bit timing: each bit = 2*(CLK_DIV+1) cycles. led_data updates at bit start and holds; led_clk=0 for first CLK_DIV+1 cycles, 1 for the rest. MSB first.
- States: IDLE -> START (32 zero bits) -> PIXELS (ROWS*COLS words) -> END (32*END_WORDS zero bits) -> IDLE.
- IDLE: if enable=1, enter START next cycle, busy=1. Latch fg_rgb, bg_rgb, brightness, scroll_pos on IDLE->START; changes mid-frame ignored until next frame.
- enable deasserted mid-frame: frame completes normally; stay IDLE afterwards.
- LED word: {3'b111, brightness, B, G, R}.
- Physical LED p (0..ROWS*COLS-1): r = p/COLS, k = p%COLS; window column x = (SERPENTINE && r even) ? COLS-1-k : k.
- Message column m = (scroll_pos + x) mod (NUM_CHARS*COLS); char = m/COLS, bit = COLS-1-(m%COLS) of glyph[char][r]. Bit 1 -> fg colour, 0 -> bg colour. Message wraps seamlessly.
- Frame end: frame_done=1 for one cycle on the cycle after last END bit completes, busy=0, led_clk=0, led_data=0. If scroll_en=1, frame counter increments; on reaching STEP_FRAMES it clears and scroll_pos increments, wrapping NUM_CHARS*COLS-1 -> 0. scroll_en=0: counter and position held.
- Glyph writes: accepted any cycle including mid-frame, visible from next pixel sampled (tearing allowed). Simultaneous reset and glyph_we: reset wins.
- Frame length = 32*(1+ROWS*COLS+END_WORDS) bits; defaults 2144 bits = 4288 cycles.

Test Plan:
- Defaults, reset then enable=1, glyphs empty, bg=0, brightness=0 -> 32 zero bits, 64 words 0xE0000000, 64 zero bits; frame_done exactly 4288 cycles after START entry; busy high throughout.
- glyph[0][0]=0x80, fg=0xFF0000, bg=0, brightness=31, scroll_en=0 -> LED 7 word 0xFF0000FF, all others 0xFF000000; identical on next frame.
- SERPENTINE=0, same stimulus -> LED 0 word 0xFF0000FF, others 0xFF000000.
- glyph[0][0]=0x40, glyph[1][0]=0x80, scroll_en=1, STEP_FRAMES=1 -> frame0 lit LED 6; frame1 lit LEDs 7 and 0; after 32 frames pattern equals frame0 (wrap).
- CLK_DIV=2 -> led_clk low 3 / high 3 cycles; led_data changes only at led_clk low-phase start.
- Reset asserted mid-PIXELS -> next cycle led_clk=0, led_data=0, busy=0, glyphs zero; with enable=1 new frame begins with start word; fg change mid-frame applies only next frame.

Source files
------------

// File: rtl/led_matrix_scroller.sv
// rtl/led_matrix_scroller.sv - scrolling text renderer for a serial RGB LED matrix
// Shifts start word, one word per LED and zero end words; window advances per STEP_FRAMES frames.
module led_matrix_scroller #(
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int NUM_CHARS   = 4,
  parameter int CLK_DIV     = 0,
  parameter int SERPENTINE  = 1,
  parameter int END_WORDS   = 2,
  parameter int STEP_FRAMES = 1,
  localparam int CW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1,
  localparam int RW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            scroll_en,
  input  logic [23:0]     fg_rgb,
  input  logic [23:0]     bg_rgb,
  input  logic [4:0]      brightness,
  input  logic            glyph_we,
  input  logic [CW-1:0]   glyph_char,
  input  logic [RW-1:0]   glyph_row,
  input  logic [COLS-1:0] glyph_data,
  output logic            led_clk,
  output logic            led_data,
  output logic            busy,
  output logic            frame_done
);

  localparam int KW  = $clog2(COLS);
  localparam int MSG = NUM_CHARS * COLS;
  localparam int SW  = $clog2(MSG);
  localparam int DW  = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int FW  = $clog2(STEP_FRAMES + 1);
  localparam int EW  = $clog2(END_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_PIXELS, S_END} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              phase_q, phase_d;
  logic [4:0]        bit_q, bit_d;
  logic [31:0]       shift_q, shift_d;
  logic [RW-1:0]     row_q, row_d;
  logic [KW-1:0]     col_q, col_d;
  logic [EW-1:0]     end_q, end_d;
  logic [23:0]       fg_q, fg_d, bg_q, bg_d;
  logic [4:0]        br_q, br_d;
  logic [SW-1:0]     scroll_q, scroll_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              done_q, done_d;
  logic [COLS-1:0]   glyph_q [NUM_CHARS][ROWS];
  logic [COLS-1:0]   glyph_d [NUM_CHARS][ROWS];

  logic [RW-1:0]     nxt_row;
  logic [KW-1:0]     nxt_col, win_x, msg_bit;
  logic [SW:0]       msg_sum;
  logic [SW-1:0]     msg_col;
  logic [CW-1:0]     msg_char;
  logic              pix_on;
  logic [31:0]       pix_word;

  function automatic logic [31:0] led_word(input logic [23:0] rgb, input logic [4:0] br);
    return {3'b111, br, rgb[7:0], rgb[15:8], rgb[23:16]};
  endfunction

  // Word for the LED that will be shifted next, sampled at its word boundary.
  always_comb begin
    nxt_row = '0;
    nxt_col = '0;
    if (state_q == S_PIXELS) begin
      if (col_q == KW'(COLS - 1)) begin
        nxt_row = row_q + 1'b1;
      end else begin
        nxt_row = row_q;
        nxt_col = col_q + 1'b1;
      end
    end
    win_x    = (SERPENTINE != 0 && !nxt_row[0]) ? KW'(COLS - 1) - nxt_col : nxt_col;
    msg_sum  = {1'b0, scroll_q} + (SW + 1)'(win_x);
    msg_col  = (msg_sum >= (SW + 1)'(MSG)) ? SW'(msg_sum - (SW + 1)'(MSG)) : SW'(msg_sum);
    msg_char = CW'(32'(msg_col) / 32'(COLS));
    msg_bit  = KW'(32'(COLS - 1) - (32'(msg_col) % 32'(COLS)));
    pix_on   = glyph_q[msg_char][nxt_row][msg_bit];
    pix_word = pix_on ? led_word(fg_q, br_q) : led_word(bg_q, br_q);
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    row_d    = row_q;
    col_d    = col_q;
    end_d    = end_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    br_d     = br_q;
    scroll_d = scroll_q;
    frame_d  = frame_q;
    done_d   = 1'b0;
    glyph_d  = glyph_q;
    if (glyph_we) glyph_d[glyph_char][glyph_row] = glyph_data;

    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d = S_START;
        fg_d    = fg_rgb;
        bg_d    = bg_rgb;
        br_d    = brightness;
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        shift_d = '0;
      end
    end else if (div_q != DW'(CLK_DIV)) begin
      div_d = div_q + 1'b1;
    end else if (!phase_q) begin
      div_d   = '0;
      phase_d = 1'b1;
    end else begin
      div_d   = '0;
      phase_d = 1'b0;
      bit_d   = bit_q + 1'b1;
      shift_d = {shift_q[30:0], 1'b0};
      if (bit_q == 5'd31) begin
        case (state_q)
          S_START: begin
            state_d = S_PIXELS;
            row_d   = nxt_row;
            col_d   = nxt_col;
            shift_d = pix_word;
          end
          S_PIXELS: begin
            if (row_q == RW'(ROWS - 1) && col_q == KW'(COLS - 1)) begin
              state_d = S_END;
              end_d   = '0;
              shift_d = '0;
            end else begin
              row_d   = nxt_row;
              col_d   = nxt_col;
              shift_d = pix_word;
            end
          end
          default: begin
            if (end_q == EW'(END_WORDS - 1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              if (scroll_en) begin
                if (frame_q == FW'(STEP_FRAMES - 1)) begin
                  frame_d  = '0;
                  scroll_d = (scroll_q == SW'(MSG - 1)) ? '0 : scroll_q + 1'b1;
                end else begin
                  frame_d = frame_q + 1'b1;
                end
              end
            end else begin
              end_d = end_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      shift_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      end_q    <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      br_q     <= '0;
      scroll_q <= '0;
      frame_q  <= '0;
      done_q   <= 1'b0;
      glyph_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      row_q    <= row_d;
      col_q    <= col_d;
      end_q    <= end_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      br_q     <= br_d;
      scroll_q <= scroll_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
      glyph_q  <= glyph_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign led_clk    = busy && phase_q;
  assign led_data   = busy && shift_q[31];
  assign frame_done = done_q;

endmodule

// File: tb/tb_led_matrix_scroller.sv
// tb/tb_led_matrix_scroller.sv - directed bench for led_matrix_scroller
// Default instance plus a small linear-wired, divided-clock instance.
module tb_led_matrix_scroller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, scroll_en;
  logic [23:0] fg, bg;
  logic [4:0]  br;
  logic        en1, gwe1, lclk1, ldat1, busy1, fd1;
  logic [1:0]  gch1;
  logic [2:0]  grow1;
  logic [7:0]  gdat1;
  logic        en2, gwe2, lclk2, ldat2, busy2, fd2;
  logic [0:0]  gch2, grow2;
  logic [1:0]  gdat2;

  led_matrix_scroller u_dut1 (
    .clk(clk), .reset(reset), .enable(en1), .scroll_en(scroll_en),
    .fg_rgb(fg), .bg_rgb(bg), .brightness(br),
    .glyph_we(gwe1), .glyph_char(gch1), .glyph_row(grow1), .glyph_data(gdat1),
    .led_clk(lclk1), .led_data(ldat1), .busy(busy1), .frame_done(fd1)
  );

  led_matrix_scroller #(
    .COLS(2), .ROWS(2), .NUM_CHARS(2), .CLK_DIV(2), .SERPENTINE(0),
    .END_WORDS(1), .STEP_FRAMES(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .enable(en2), .scroll_en(scroll_en),
    .fg_rgb(fg), .bg_rgb(bg), .brightness(br),
    .glyph_we(gwe2), .glyph_char(gch2), .glyph_row(grow2), .glyph_data(gdat2),
    .led_clk(lclk2), .led_data(ldat2), .busy(busy2), .frame_done(fd2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] words1 [0:127];
  logic [31:0] sh1 = '0;
  int w1 = 0, nb1 = 0, st1 = 0;
  logic pc1 = 1'b0, pb1 = 1'b0;
  always @(negedge clk) begin
    if (busy1 && !pb1) begin st1 = cyc; w1 = 0; nb1 = 0; end
    if (busy1 && lclk1 && !pc1) begin
      sh1 = {sh1[30:0], ldat1};
      nb1++;
      if (nb1 == 32) begin
        if (w1 < 128) words1[w1] = sh1;
        w1++;
        nb1 = 0;
      end
    end
    pc1 = lclk1;
    pb1 = busy1;
  end

  logic [31:0] words2 [0:15];
  logic [31:0] sh2 = '0;
  int w2 = 0, nb2 = 0, st2 = 0, run2 = 1, tv2 = 0, dv2 = 0, ed2 = 0;
  logic pc2 = 1'b0, pb2 = 1'b0, pd2 = 1'b0;
  always @(negedge clk) begin
    if (busy2 && !pb2) begin st2 = cyc; w2 = 0; nb2 = 0; end
    if (busy2 && pb2) begin
      if (lclk2 == pc2) run2++;
      else begin
        if (run2 != 3) tv2++;
        run2 = 1;
        ed2++;
      end
      if (ldat2 != pd2 && !(pc2 && !lclk2)) dv2++;
    end else run2 = 1;
    if (busy2 && lclk2 && !pc2) begin
      sh2 = {sh2[30:0], ldat2};
      nb2++;
      if (nb2 == 32) begin
        if (w2 < 16) words2[w2] = sh2;
        w2++;
        nb2 = 0;
      end
    end
    pc2 = lclk2;
    pb2 = busy2;
    pd2 = ldat2;
  end

  task automatic wait_fd1(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!fd1 && n < 20000);
    chk({tag, " frame_done"}, {31'b0, fd1}, 32'd1);
  endtask

  task automatic wait_fd2(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!fd2 && n < 20000);
    chk({tag, " frame_done"}, {31'b0, fd2}, 32'd1);
  endtask

  task automatic check_frame1(input string tag, input logic [63:0] lit,
                              input logic [31:0] on_w, input logic [31:0] off_w);
    chk({tag, " words"}, 32'(w1), 32'd67);
    chk({tag, " len"}, 32'(cyc - st1), 32'd4288);
    chk({tag, " idle"}, {29'b0, busy1, lclk1, ldat1}, 32'd0);
    chk({tag, " start"}, words1[0], 32'd0);
    for (int p = 0; p < 64; p++)
      chk($sformatf("%s led%0d", tag, p), words1[1+p], lit[p] ? on_w : off_w);
    chk({tag, " end0"}, words1[65], 32'd0);
    chk({tag, " end1"}, words1[66], 32'd0);
  endtask

  task automatic check_frame2(input string tag, input logic [3:0] lit,
                              input logic [31:0] on_w, input logic [31:0] off_w);
    chk({tag, " words"}, 32'(w2), 32'd6);
    chk({tag, " len"}, 32'(cyc - st2), 32'd1152);
    chk({tag, " start"}, words2[0], 32'd0);
    for (int p = 0; p < 4; p++)
      chk($sformatf("%s led%0d", tag, p), words2[1+p], lit[p] ? on_w : off_w);
    chk({tag, " end0"}, words2[5], 32'd0);
  endtask

  task automatic gw1(input logic [1:0] c, input logic [2:0] r, input logic [7:0] d);
    @(negedge clk);
    gwe1 = 1'b1; gch1 = c; grow1 = r; gdat1 = d;
    @(negedge clk);
    gwe1 = 1'b0;
  endtask

  task automatic gw2(input logic c, input logic r, input logic [1:0] d);
    @(negedge clk);
    gwe2 = 1'b1; gch2 = c; grow2 = r; gdat2 = d;
    @(negedge clk);
    gwe2 = 1'b0;
  endtask

  logic [3:0] exp2 [0:8] = '{4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0001,
                             4'b0001, 4'b0000, 4'b0000, 4'b0010};

  initial begin
    reset = 1'b1; scroll_en = 1'b0; fg = 24'h123456; bg = '0; br = '0;
    en1 = 1'b0; gwe1 = 1'b0; gch1 = '0; grow1 = '0; gdat1 = '0;
    en2 = 1'b0; gwe2 = 1'b0; gch2 = '0; grow2 = '0; gdat2 = '0;
    repeat (3) @(negedge clk);
    chk("rst outputs", {28'b0, lclk1, ldat1, busy1, fd1}, 32'd0);
    reset = 1'b0;

    @(negedge clk);
    en1 = 1'b1; en2 = 1'b1;
    wait_fd2("t1 d2");
    en2 = 1'b0;
    check_frame2("t1 d2", 4'b0000, 32'hE000_0000, 32'hE000_0000);
    wait_fd1("t1 d1");
    en1 = 1'b0;
    check_frame1("t1 d1", 64'h0, 32'hE000_0000, 32'hE000_0000);

    gw1(2'd0, 3'd0, 8'h80);
    gw2(1'b0, 1'b0, 2'b10);
    fg = 24'hFF0000; bg = '0; br = 5'd31;
    @(negedge clk);
    en1 = 1'b1; en2 = 1'b1;
    wait_fd2("t2 d2");
    en2 = 1'b0;
    check_frame2("t2 d2", 4'b0001, 32'hFF00_00FF, 32'hFF00_0000);
    wait_fd1("t2 f0");
    check_frame1("t2 f0", 64'h80, 32'hFF00_00FF, 32'hFF00_0000);
    wait_fd1("t2 f1");
    en1 = 1'b0;
    check_frame1("t2 f1", 64'h80, 32'hFF00_00FF, 32'hFF00_0000);

    gw1(2'd0, 3'd0, 8'h40);
    gw1(2'd1, 3'd0, 8'h80);
    scroll_en = 1'b1;
    @(negedge clk);
    en1 = 1'b1;
    wait_fd1("t3 f0");
    check_frame1("t3 f0", 64'h40, 32'hFF00_00FF, 32'hFF00_0000);
    wait_fd1("t3 f1");
    en1 = 1'b0;
    check_frame1("t3 f1", 64'h81, 32'hFF00_00FF, 32'hFF00_0000);

    gw2(1'b0, 1'b0, 2'b01);
    gw2(1'b1, 1'b0, 2'b10);
    @(negedge clk);
    en2 = 1'b1;
    for (int f = 0; f < 9; f++) begin
      wait_fd2($sformatf("t4 f%0d", f));
      if (f == 8) en2 = 1'b0;
      check_frame2($sformatf("t4 f%0d", f), exp2[f], 32'hFF00_00FF, 32'hFF00_0000);
    end

    scroll_en = 1'b0;
    @(negedge clk);
    en1 = 1'b1;
    repeat (1000) @(negedge clk);
    chk("t5 mid busy", {31'b0, busy1}, 32'd1);
    reset = 1'b1; en1 = 1'b0;
    gwe1 = 1'b1; gch1 = 2'd0; grow1 = 3'd0; gdat1 = 8'hFF;
    @(negedge clk);
    reset = 1'b0; gwe1 = 1'b0;
    chk("t5 after rst", {28'b0, lclk1, ldat1, busy1, fd1}, 32'd0);
    gw1(2'd0, 3'd1, 8'h80);
    @(negedge clk);
    en1 = 1'b1;
    repeat (100) @(negedge clk);
    fg = 24'h0000FF;
    wait_fd1("t5 f0");
    check_frame1("t5 f0", 64'h100, 32'hFF00_00FF, 32'hFF00_0000);
    wait_fd1("t5 f1");
    en1 = 1'b0;
    check_frame1("t5 f1", 64'h100, 32'hFFFF_0000, 32'hFF00_0000);

    chk("d2 clk phase len", 32'(tv2), 32'd0);
    chk("d2 data at fall only", 32'(dv2), 32'd0);
    chk("d2 clk toggled", {31'b0, ed2 > 0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
